// File: rtl/sauria_pkg.sv
// Shared types and helpers for the SAURIA PE partial-sum stage.
package sauria_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } psum_state_t;

  // Drain counter width: enough to hold CHAIN_LEN, never narrower than 3 bits.
  function automatic int CHAIN_CNT_W(input int chain_len);
    int w;
    w = $clog2(chain_len + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/psum_shadow_ctrl.sv
// Shadow occupancy FSM, drain counter and sticky collision flag for the
// partial-sum context-swap stage.
module psum_shadow_ctrl
  import sauria_pkg::*;
#(
  parameter int CHAIN_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_cswitch,
  input  logic i_shift_en,
  input  logic i_err_clr,
  output logic o_swap,
  output logic o_load,
  output logic o_busy,
  output logic o_err
);

  localparam int CNT_W = CHAIN_CNT_W(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  psum_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             collide;

  assign o_swap  = i_cswitch;
  assign o_load  = i_shift_en && !i_cswitch;
  assign o_busy  = (state_q != EMPTY);
  assign o_err   = err_q;
  assign collide = i_cswitch && ((state_q != EMPTY) || i_shift_en);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // The swap always wins: any context switch lands in FULL with a fresh count.
    if (i_cswitch) begin
      state_d = FULL;
      cnt_d   = '0;
    end else if (i_shift_en) begin
      case (state_q)
        EMPTY: ;
        FULL: begin
          if (CHAIN_LEN == 1) begin
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            state_d = DRAIN;
            cnt_d   = CNT_ONE;
          end
        end
        DRAIN: begin
          if (cnt_q + CNT_ONE == CNT_LAST) begin
            state_d = EMPTY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          cnt_d   = '0;
        end
      endcase
    end

    if (i_err_clr) err_d = 1'b0;
    if (collide)   err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: rtl/psum_ctx_accumulator.sv
// PE partial-sum accumulator with context-swap shadow register on the column
// shift chain. Define PSUM_PRELOAD_EN to load the accumulator from the shadow on a swap.
module psum_ctx_accumulator
  import sauria_pkg::*;
#(
  parameter int OC_W      = 16,
  parameter int CHAIN_LEN = 8
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [OC_W-1:0] i_sum,
  input  logic            i_en,
  output logic [OC_W-1:0] o_acc,
  input  logic            i_cswitch,
  input  logic            i_shift_en,
  input  logic [OC_W-1:0] i_shift_in,
  output logic [OC_W-1:0] o_shift_out,
  output logic            o_shadow_busy,
  input  logic            i_err_clr,
  output logic            o_err
);

  logic [OC_W-1:0] acc_q, acc_d;
  logic [OC_W-1:0] shadow_q, shadow_d;
  logic            swap;
  logic            load;

  psum_shadow_ctrl #(
    .CHAIN_LEN(CHAIN_LEN)
  ) u_ctrl (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_cswitch  (i_cswitch),
    .i_shift_en (i_shift_en),
    .i_err_clr  (i_err_clr),
    .o_swap     (swap),
    .o_load     (load),
    .o_busy     (o_shadow_busy),
    .o_err      (o_err)
  );

  always_comb begin
    acc_d    = acc_q;
    shadow_d = shadow_q;
    if (swap) begin
      // Capture this cycle's adder result if enabled so no accumulation is lost.
      shadow_d = i_en ? i_sum : acc_q;
`ifdef PSUM_PRELOAD_EN
      acc_d    = shadow_q;
`else
      acc_d    = '0;
`endif
    end else begin
      if (i_en) acc_d    = i_sum;
      if (load) shadow_d = i_shift_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc_q    <= '0;
      shadow_q <= '0;
    end else begin
      acc_q    <= acc_d;
      shadow_q <= shadow_d;
    end
  end

  assign o_acc       = acc_q;
  assign o_shift_out = shadow_q;

endmodule

// File: tb/tb_psum_ctx_accumulator.sv
// Self-checking bench for psum_ctx_accumulator: directed test-plan steps plus
// randomized traffic compared every cycle against a behavioural model.
module tb_psum_ctx_accumulator;

  localparam int OC_W      = 16;
  localparam int CHAIN_LEN = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [OC_W-1:0] sum = '0;
  logic            en = 1'b0;
  logic [OC_W-1:0] acc;
  logic            cs = 1'b0;
  logic            sh = 1'b0;
  logic [OC_W-1:0] shin = '0;
  logic [OC_W-1:0] sout;
  logic            busy;
  logic            clr = 1'b0;
  logic            err;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  // Behavioural model: occupancy is just "busy" plus number of shifts taken.
  logic [OC_W-1:0] m_acc = '0;
  logic [OC_W-1:0] m_shadow = '0;
  bit              m_busy = 1'b0;
  int              m_shifts = 0;
  bit              m_err = 1'b0;

  psum_ctx_accumulator #(.OC_W(OC_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .i_clk         (clk),
    .i_rstn        (rst_n),
    .i_sum         (sum),
    .i_en          (en),
    .o_acc         (acc),
    .i_cswitch     (cs),
    .i_shift_en    (sh),
    .i_shift_in    (shin),
    .o_shift_out   (sout),
    .o_shadow_busy (busy),
    .i_err_clr     (clr),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    logic [OC_W-1:0] old_shadow;
    if (!rst_n) begin
      m_acc = '0; m_shadow = '0; m_busy = 0; m_shifts = 0; m_err = 0;
    end else begin
      old_shadow = m_shadow;
      if (clr) m_err = 0;
      if (cs && (m_busy || sh)) m_err = 1;
      if (cs) begin
        m_shadow = en ? sum : m_acc;
`ifdef PSUM_PRELOAD_EN
        m_acc = old_shadow;
`else
        m_acc = '0;
`endif
        m_busy = 1;
        m_shifts = 0;
      end else begin
        if (en) m_acc = sum;
        if (sh) begin
          m_shadow = shin;
          if (m_busy) begin
            m_shifts++;
            if (m_shifts == CHAIN_LEN) begin
              m_busy = 0;
              m_shifts = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checks += 4;
      if (acc !== m_acc) begin
        errors++; $display("FAIL model_acc t=%0t got=%h exp=%h", $time, acc, m_acc);
      end
      if (sout !== m_shadow) begin
        errors++; $display("FAIL model_shift_out t=%0t got=%h exp=%h", $time, sout, m_shadow);
      end
      if (busy !== m_busy) begin
        errors++; $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, m_busy);
      end
      if (err !== m_err) begin
        errors++; $display("FAIL model_err t=%0t got=%b exp=%b", $time, err, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [OC_W-1:0] got, input logic [OC_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), return at the next negedge.
  task automatic step(input logic e, input logic [OC_W-1:0] s, input logic c,
                      input logic h, input logic [OC_W-1:0] si, input logic cl);
    en = e; sum = s; cs = c; sh = h; shin = si; clr = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [OC_W-1:0] exp_pre;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;
    chk("reset_acc", acc, 16'h0);
    chk("reset_shift_out", sout, 16'h0);
    chk("reset_busy", {15'b0, busy}, 16'h0);
    chk("reset_err", {15'b0, err}, 16'h0);

    for (int i = 1; i <= 4; i++) begin
      step(1, OC_W'(5 * i), 0, 0, 0, 0);
      chk("accumulate", acc, OC_W'(5 * i));
    end
    chk("acc_busy", {15'b0, busy}, 16'h0);

    step(1, 16'd27, 1, 0, 0, 0);
    chk("cswitch_shift_out", sout, 16'd27);
    chk("cswitch_acc", acc, 16'd0);
    chk("cswitch_busy", {15'b0, busy}, 16'h1);

    for (int i = 1; i <= CHAIN_LEN; i++) begin
      step(0, 0, 0, 1, 16'h11, 0);
      if (i == 1) chk("drain_first", sout, 16'h11);
      if (i == CHAIN_LEN - 1) chk("drain_busy_7", {15'b0, busy}, 16'h1);
    end
    chk("drain_busy_done", {15'b0, busy}, 16'h0);
    chk("drain_err", {15'b0, err}, 16'h0);

    step(0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 16'h22, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("early_cs_err", {15'b0, err}, 16'h1);
    chk("early_cs_busy", {15'b0, busy}, 16'h1);
    step(0, 0, 0, 0, 0, 1);
    chk("err_clr", {15'b0, err}, 16'h0);
    repeat (CHAIN_LEN) step(0, 0, 0, 1, 16'h33, 0);
    chk("redrain_busy", {15'b0, busy}, 16'h0);

    step(1, 16'd9, 0, 0, 0, 0);
    step(0, 0, 1, 1, 16'd3, 0);
    chk("cs_shift_out", sout, 16'd9);
    chk("cs_shift_err", {15'b0, err}, 16'h1);
    step(0, 0, 0, 0, 0, 1);

    repeat (CHAIN_LEN) step(0, 0, 0, 1, 16'h40, 0);
    chk("preload_shadow", sout, 16'h40);
`ifdef PSUM_PRELOAD_EN
    exp_pre = 16'h40;
`else
    exp_pre = 16'h0;
`endif
    step(0, 0, 1, 0, 0, 0);
    chk("preload_acc", acc, exp_pre);

    step(1, 16'h1234, 0, 1, 16'h55, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_acc", acc, 16'h0);
    chk("async_rst_shift_out", sout, 16'h0);
    chk("async_rst_busy", {15'b0, busy}, 16'h0);
    step(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(3) != 0), OC_W'($urandom), ($urandom_range(9) == 0),
           ($urandom_range(2) == 0), OC_W'($urandom), ($urandom_range(15) == 0));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
